// File: rtl/regfile_mp.sv
// Multi-port register file with two clocked write ports, combinational reads,
// optional write-to-read bypass, hardwired zero register and a clear sequencer.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_req,
    output logic                       busy,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr0_en,
    input  logic [ADDR_W-1:0]          wr0_addr,
    input  logic [DATA_W-1:0]          wr0_data,
    input  logic                       wr1_en,
    input  logic [ADDR_W-1:0]          wr1_addr,
    input  logic [DATA_W-1:0]          wr1_data,
    output logic                       wr_conflict
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                conflict_q, conflict_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr0_ok, wr1_ok;

    assign busy        = (state_q == CLEAR);
    assign wr_conflict = conflict_q;

    // Writes to the zero register are dropped, but still count toward a conflict.
    assign wr0_ok = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
    assign wr1_ok = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        conflict_d = 1'b0;
        case (state_q)
            IDLE: begin
                conflict_d = wr0_en && wr1_en && (wr0_addr == wr1_addr);
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
        end
    end

    // Storage has no reset; port 1 is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[cnt_q] <= '0;
            end else begin
                if (wr0_ok) begin
                    mem_q[wr0_addr] <= wr0_data;
                end
                if (wr1_ok) begin
                    mem_q[wr1_addr] <= wr1_data;
                end
            end
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            rv = mem_q[ra];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rv = '0;
            end else if ((BYPASS != 0) && (state_q == IDLE)) begin
                if (wr1_en && (wr1_addr == ra)) begin
                    rv = wr1_data;
                end else if (wr0_en && (wr0_addr == ra)) begin
                    rv = wr0_data;
                end
            end
            if (state_q == CLEAR) begin
                rv = '0;
            end
            rd_data[i*DATA_W +: DATA_W] = rv;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a bypassing and a non-bypassing instance
// share stimulus and are compared against an array-based reference model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_req = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic        wr0_en = 1'b0;
    logic [4:0]  wr0_addr = '0;
    logic [31:0] wr0_data = '0;
    logic        wr1_en = 1'b0;
    logic [4:0]  wr1_addr = '0;
    logic [31:0] wr1_data = '0;

    logic        busy_b, busy_n, conf_b, conf_n;
    logic [63:0] rd_data_b, rd_data_n;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_mem [32];
    int          m_left = 0;
    bit          m_conf = 1'b0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
        .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .wr_conflict(conf_b)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_n),
        .rd_addr(rd_addr), .rd_data(rd_data_n),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .wr_conflict(conf_n)
    );

    // Reference: a clear zeroes entries 0..31 in order, one per edge, and the
    // file reports busy for as many edges as entries remain to be cleared.
    task automatic model_edge();
        if (rst) begin
            m_left = 32;
            m_conf = 1'b0;
        end else if (m_left > 0) begin
            m_mem[32 - m_left] = '0;
            m_left--;
            m_conf = 1'b0;
        end else begin
            m_conf = wr0_en && wr1_en && (wr0_addr == wr1_addr);
            if (wr0_en && wr0_addr != 0) m_mem[wr0_addr] = wr0_data;
            if (wr1_en && wr1_addr != 0) m_mem[wr1_addr] = wr1_data;
            if (clr_req) m_left = 32;
        end
    endtask

    function automatic logic [31:0] exp_rd(input int p, input bit byp);
        logic [4:0] a;
        a = rd_addr[p*5 +: 5];
        if (m_left > 0 || a == 0) return 32'h0;
        if (byp && wr1_en && wr1_addr == a) return wr1_data;
        if (byp && wr0_en && wr0_addr == a) return wr0_data;
        return m_mem[a];
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        clr_req = 1'b0;
        wr0_en  = 1'b0;
        wr1_en  = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        rst = 1'b1;
        repeat (3) begin
            step();
            n_checks++;
            if (busy_b !== 1'b1 || busy_n !== 1'b1)
                $display("FAIL reset_busy_hold: got %b/%b expected 1", busy_b, busy_n);
            else n_pass++;
        end
        rst = 1'b0;
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            step();
            n++;
        end
        n_checks++;
        if (n != 32) $display("FAIL reset_busy_len: got %0d expected 32", n);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            rd_addr = {5'(2*k + 1), 5'(2*k)};
            #1;
            n_checks++;
            if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0)
                $display("FAIL reset_zero a=%0d: got %h/%h expected 0", 2*k, rd_data_b, rd_data_n);
            else n_pass++;
        end
        n_checks++;
        if (conf_b !== 1'b0 || busy_n !== 1'b0)
            $display("FAIL reset_idle: got conf=%b busy=%b expected 0/0", conf_b, busy_n);
        else n_pass++;
    endtask

    task automatic test_write_read();
        idle_inputs();
        wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
        step();
        wr0_en = 1'b0;
        rd_addr = {5'd6, 5'd5};
        #1;
        n_checks++;
        if (rd_data_b[31:0] !== 32'hDEADBEEF || rd_data_n[31:0] !== 32'hDEADBEEF)
            $display("FAIL wr_rd_5: got %h/%h expected deadbeef", rd_data_b[31:0], rd_data_n[31:0]);
        else n_pass++;
        n_checks++;
        if (rd_data_b[63:32] !== 32'h0 || rd_data_n[63:32] !== 32'h0)
            $display("FAIL wr_rd_6: got %h/%h expected 0", rd_data_b[63:32], rd_data_n[63:32]);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'h1234;
        rd_addr = {5'd0, 5'd0};
        #1;
        n_checks++;
        if (rd_data_b !== 64'h0) $display("FAIL zero_bypass: got %h expected 0", rd_data_b);
        else n_pass++;
        step();
        wr1_en = 1'b0;
        #1;
        n_checks++;
        if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0)
            $display("FAIL zero_after: got %h/%h expected 0", rd_data_b, rd_data_n);
        else n_pass++;
    endtask

    task automatic test_collision();
        idle_inputs();
        wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h11;
        wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h22;
        rd_addr = {5'd7, 5'd7};
        #1;
        n_checks++;
        if (rd_data_b !== {32'h22, 32'h22}) $display("FAIL coll_bypass: got %h expected 22 on both", rd_data_b);
        else n_pass++;
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (conf_b !== 1'b1 || conf_n !== 1'b1) $display("FAIL coll_flag: got %b/%b expected 1", conf_b, conf_n);
        else n_pass++;
        n_checks++;
        if (rd_data_b[31:0] !== 32'h22 || rd_data_n[31:0] !== 32'h22)
            $display("FAIL coll_entry: got %h/%h expected 22", rd_data_b[31:0], rd_data_n[31:0]);
        else n_pass++;
        step();
        n_checks++;
        if (conf_b !== 1'b0) $display("FAIL coll_pulse: got %b expected 0", conf_b);
        else n_pass++;
    endtask

    task automatic test_bypass_off();
        idle_inputs();
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h5;
        step();
        wr0_data = 32'hA;
        rd_addr = {5'd3, 5'd3};
        #1;
        n_checks++;
        if (rd_data_n[31:0] !== 32'h5) $display("FAIL nobyp_old: got %h expected 5", rd_data_n[31:0]);
        else n_pass++;
        n_checks++;
        if (rd_data_b[31:0] !== 32'hA) $display("FAIL byp_new: got %h expected a", rd_data_b[31:0]);
        else n_pass++;
        step();
        wr0_en = 1'b0;
        #1;
        n_checks++;
        if (rd_data_n[31:0] !== 32'hA) $display("FAIL nobyp_next: got %h expected a", rd_data_n[31:0]);
        else n_pass++;
    endtask

    task automatic test_mid_clear();
        int n;
        idle_inputs();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n_checks++;
        if (busy_b !== 1'b1) $display("FAIL clr_start: got %b expected 1", busy_b);
        else n_pass++;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            clr_req  = 1'b1;
            wr0_en   = 1'b1; wr0_addr = 5'($urandom_range(1, 31)); wr0_data = $urandom;
            wr1_en   = 1'b1; wr1_addr = wr0_addr;                 wr1_data = $urandom;
            rd_addr  = {wr0_addr, wr0_addr};
            #1;
            n_checks++;
            if (rd_data_b !== 64'h0 || conf_b !== 1'b0)
                $display("FAIL busy_quiet: got rd=%h conf=%b expected 0/0", rd_data_b, conf_b);
            else n_pass++;
            step();
            n++;
        end
        idle_inputs();
        n_checks++;
        if (n != 32) $display("FAIL midclr_len: got %0d expected 32", n);
        else n_pass++;
        step();
        n_checks++;
        if (busy_b !== 1'b0 || conf_b !== 1'b0)
            $display("FAIL clr_ignored: got busy=%b conf=%b expected 0/0", busy_b, conf_b);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            rd_addr = {5'(2*k + 1), 5'(2*k)};
            #1;
            n_checks++;
            if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0)
                $display("FAIL midclr_zero a=%0d: got %h/%h expected 0", 2*k, rd_data_b, rd_data_n);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int c = 0; c < 400; c++) begin
            clr_req  = ($urandom_range(0, 59) == 0);
            wr0_en   = $urandom_range(0, 1) == 1;
            wr0_addr = 5'($urandom_range(0, 7));
            wr0_data = $urandom;
            wr1_en   = $urandom_range(0, 1) == 1;
            wr1_addr = 5'($urandom_range(0, 7));
            wr1_data = $urandom;
            rd_addr  = {5'($urandom_range(0, 8)), 5'($urandom_range(0, 8))};
            #1;
            for (int p = 0; p < 2; p++) begin
                e = exp_rd(p, 1'b1);
                n_checks++;
                if (rd_data_b[p*32 +: 32] !== e)
                    $display("FAIL rand_byp c=%0d p=%0d: got %h expected %h", c, p, rd_data_b[p*32 +: 32], e);
                else n_pass++;
                e = exp_rd(p, 1'b0);
                n_checks++;
                if (rd_data_n[p*32 +: 32] !== e)
                    $display("FAIL rand_nobyp c=%0d p=%0d: got %h expected %h", c, p, rd_data_n[p*32 +: 32], e);
                else n_pass++;
            end
            n_checks++;
            if (busy_b !== (m_left > 0) || busy_n !== (m_left > 0))
                $display("FAIL rand_busy c=%0d: got %b/%b expected %b", c, busy_b, busy_n, m_left > 0);
            else n_pass++;
            step();
            n_checks++;
            if (conf_b !== m_conf || conf_n !== m_conf)
                $display("FAIL rand_conf c=%0d: got %b/%b expected %b", c, conf_b, conf_n, m_conf);
            else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_collision();
        test_bypass_off();
        test_mid_clear();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
